// File: rtl/bg_pkg.sv
// Shared background-layer definitions: map geometry, attribute word layout and colour key.
// Also used by game_engine and the object renderer.
package bg_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned TILE_W   = 16;
    localparam int unsigned MAP_COLS = 40;
    localparam int unsigned MAP_ROWS = 30;
    localparam int unsigned PIX_W    = 12;

    localparam logic [11:0] TRANSP_KEY = 12'hF0F;

    localparam int unsigned COL_LSB = 0;
    localparam int unsigned ROW_LSB = 3;
    localparam int unsigned XFLIP   = 6;
    localparam int unsigned YFLIP   = 7;
    localparam int unsigned EN      = 8;

    typedef struct packed {
        logic       en;
        logic       yflip;
        logic       xflip;
        logic [2:0] row;
        logic [2:0] col;
    } tile_attr_t;

    function automatic tile_attr_t decode_attr(input logic [31:0] word);
        tile_attr_t a;
        a.col   = word[COL_LSB +: 3];
        a.row   = word[ROW_LSB +: 3];
        a.xflip = word[XFLIP];
        a.yflip = word[YFLIP];
        a.en    = word[EN];
        return a;
    endfunction

    function automatic logic is_opaque(input logic en, input logic [11:0] colour);
        return en && (colour != TRANSP_KEY);
    endfunction

endpackage

// File: rtl/bg_map_addr_gen.sv
// First pipeline stage: applies fine scroll, wraps the map column and forms the
// registered tile-map RAM address (row*40+col) plus the in-tile pixel offsets.
module bg_map_addr_gen
    import bg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        video_on_i,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic [3:0]  off_i,
    output logic [15:0] rd_addr_o,
    output logic [3:0]  fx_o,
    output logic [3:0]  fy_o,
    output logic        vid_o
);

    logic [10:0] ex_s;
    logic [6:0]  col_raw_s;
    logic [6:0]  col_s;
    logic [5:0]  row_s;
    logic [15:0] addr_d;
    logic        vid_d;

    logic [15:0] addr_q;
    logic [3:0]  fx_q;
    logic [3:0]  fy_q;
    logic        vid_q;

    // Scrolled column with single-step wrap (ex never exceeds 654, so col_raw <= 40).
    always_comb begin
        ex_s      = {1'b0, x_i} + {7'd0, off_i};
        col_raw_s = ex_s[10:4];
        if (col_raw_s >= 7'(MAP_COLS)) begin
            col_s = col_raw_s - 7'(MAP_COLS);
        end else begin
            col_s = col_raw_s;
        end
        row_s  = y_i[9:4];
        addr_d = ({10'd0, row_s} << 5) + ({10'd0, row_s} << 3) + {9'd0, col_s};
        vid_d  = video_on_i & (y_i < 10'(V_ACTIVE));
    end

    // Stage registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q <= 16'd0;
            fx_q   <= 4'd0;
            fy_q   <= 4'd0;
            vid_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            fx_q   <= ex_s[3:0];
            fy_q   <= y_i[3:0];
            vid_q  <= vid_d;
        end
    end

    assign rd_addr_o = addr_q;
    assign fx_o      = fx_q;
    assign fy_o      = fy_q;
    assign vid_o     = vid_q;

endmodule

// File: rtl/bg_tile_renderer.sv
// Background tile renderer: map lookup, attribute decode with flips, pattern ROM fetch
// and colour keying, four clocks from x/y sample to RGB output.
module bg_tile_renderer
    import bg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [3:0]  bg_x_offset,
    output logic [15:0] bg_ram_rd_addr,
    input  logic [31:0] bg_ram_rd_data,
    output logic [13:0] tile_rom_addr,
    input  logic [11:0] tile_rom_data,
    output logic [11:0] bg_rgb,
    output logic        bg_pixel_on,
    output logic        bg_video_on
);

    logic [3:0]  off_d, off_q;
    logic [3:0]  fx1_s, fy1_s;
    logic        vid1_s;

    tile_attr_t  attr_s;
    logic [3:0]  px_s, py_s;
    logic [13:0] rom_addr_d, rom_addr_q;
    logic        en2_d, en2_q, vid2_q;
    logic        en3_q, vid3_q;
    logic [11:0] rgb_d, rgb_q;
    logic        on_d, on_q, vid4_q;
    logic        unused_attr_s;

    assign unused_attr_s = ^bg_ram_rd_data[31:9];

    // Scroll offset only follows the input during blanking so a line never tears.
    always_comb begin
        off_d = off_q;
        if (!video_on) begin
            off_d = bg_x_offset;
        end else begin
            off_d = off_q;
        end
    end

    bg_map_addr_gen u_addr_gen (
        .clk_i      (clk),
        .rst_n_i    (reset),
        .video_on_i (video_on),
        .x_i        (x),
        .y_i        (y),
        .off_i      (off_q),
        .rd_addr_o  (bg_ram_rd_addr),
        .fx_o       (fx1_s),
        .fy_o       (fy1_s),
        .vid_o      (vid1_s)
    );

    // Attribute decode, flip and colour-key selection for the later stages.
    always_comb begin
        attr_s     = decode_attr(bg_ram_rd_data);
        px_s       = fx1_s ^ {4{attr_s.xflip}};
        py_s       = fy1_s ^ {4{attr_s.yflip}};
        rom_addr_d = {attr_s.row, attr_s.col, py_s, px_s};
        en2_d      = vid1_s & attr_s.en;
        rgb_d      = 12'd0;
        on_d       = 1'b0;
        if (is_opaque(en3_q, tile_rom_data)) begin
            rgb_d = tile_rom_data;
            on_d  = 1'b1;
        end else begin
            rgb_d = 12'd0;
            on_d  = 1'b0;
        end
    end

    // Offset latch and stage E2..E4 registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off_q      <= 4'd0;
            rom_addr_q <= 14'd0;
            en2_q      <= 1'b0;
            vid2_q     <= 1'b0;
            en3_q      <= 1'b0;
            vid3_q     <= 1'b0;
            rgb_q      <= 12'd0;
            on_q       <= 1'b0;
            vid4_q     <= 1'b0;
        end else begin
            off_q      <= off_d;
            rom_addr_q <= rom_addr_d;
            en2_q      <= en2_d;
            vid2_q     <= vid1_s;
            en3_q      <= en2_q;
            vid3_q     <= vid2_q;
            rgb_q      <= rgb_d;
            on_q       <= on_d;
            vid4_q     <= vid3_q;
        end
    end

    assign tile_rom_addr = rom_addr_q;
    assign bg_rgb        = rgb_q;
    assign bg_pixel_on   = on_q;
    assign bg_video_on   = vid4_q;

endmodule

// File: tb/tb_bg_tile_renderer.sv
// Directed bench for bg_tile_renderer: tile RAM answers combinationally on the read
// address, pattern ROM is a one-clock synchronous lookup.
module tb_bg_tile_renderer;

    logic        clk;
    logic        reset;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  bg_x_offset;
    logic [15:0] bg_ram_rd_addr;
    logic [31:0] bg_ram_rd_data;
    logic [13:0] tile_rom_addr;
    logic [11:0] tile_rom_data;
    logic [11:0] bg_rgb;
    logic        bg_pixel_on;
    logic        bg_video_on;

    logic [31:0] ram [0:2047];
    logic [13:0] rom_match;
    logic [11:0] rom_word;

    int checks;
    int failures;

    bg_tile_renderer dut (
        .clk            (clk),
        .reset          (reset),
        .video_on       (video_on),
        .x              (x),
        .y              (y),
        .bg_x_offset    (bg_x_offset),
        .bg_ram_rd_addr (bg_ram_rd_addr),
        .bg_ram_rd_data (bg_ram_rd_data),
        .tile_rom_addr  (tile_rom_addr),
        .tile_rom_data  (tile_rom_data),
        .bg_rgb         (bg_rgb),
        .bg_pixel_on    (bg_pixel_on),
        .bg_video_on    (bg_video_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bg_ram_rd_data = (bg_ram_rd_addr < 16'd2048) ? ram[bg_ram_rd_addr[10:0]] : 32'd0;

    always @(posedge clk) begin
        tile_rom_data <= (tile_rom_addr == rom_match) ? rom_word : 12'h123;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        video_on    = 1'b0;
        x           = 10'd0;
        y           = 10'd0;
        bg_x_offset = 4'd0;
        for (int i = 0; i < 2048; i++) ram[i] = 32'd0;
        ram[0]    = 32'h0000_0131;
        ram[40]   = 32'h0000_0171;
        ram[1200] = 32'h0000_0131;
        rom_match = 14'h3100;
        rom_word  = 12'h0A5;

        // Fill the pipeline, then reset mid-line with video on.
        repeat (2) tick();
        reset    = 1'b1;
        video_on = 1'b1;
        repeat (6) tick();
        chk("prefill_rgb", 32'(bg_rgb), 32'h0A5);
        chk("prefill_vid", 32'(bg_video_on), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_rgb", 32'(bg_rgb), 32'd0);
        chk("rst_on", 32'(bg_pixel_on), 32'd0);
        chk("rst_vid", 32'(bg_video_on), 32'd0);
        chk("rst_rom_addr", 32'(tile_rom_addr), 32'd0);
        repeat (2) tick();
        reset = 1'b1;

        // Latency after release plus basic render of RAM[0]=0x131.
        tick();
        chk("t1_rd_addr", 32'(bg_ram_rd_addr), 32'd0);
        chk("t1_vid", 32'(bg_video_on), 32'd0);
        tick();
        chk("t2_rom_addr", 32'(tile_rom_addr), 32'h3100);
        tick();
        chk("t3_vid", 32'(bg_video_on), 32'd0);
        tick();
        chk("t4_vid", 32'(bg_video_on), 32'd1);
        chk("t4_rgb", 32'(bg_rgb), 32'h0A5);
        chk("t4_on", 32'(bg_pixel_on), 32'd1);

        // X flip, then X+Y flip.
        x         = 10'd3;
        y         = 10'd18;
        rom_match = 14'h312C;
        rom_word  = 12'h5A3;
        tick();
        chk("xflip_rd_addr", 32'(bg_ram_rd_addr), 32'd40);
        tick();
        chk("xflip_rom_addr", 32'(tile_rom_addr), 32'h312C);
        repeat (2) tick();
        chk("xflip_rgb", 32'(bg_rgb), 32'h5A3);
        chk("xflip_on", 32'(bg_pixel_on), 32'd1);
        ram[40] = 32'h0000_01F1;
        tick();
        chk("xyflip_rom_addr", 32'(tile_rom_addr), 32'h31DC);

        // Column wrap with offset 15 at the right edge, then bottom row.
        video_on    = 1'b0;
        bg_x_offset = 4'd15;
        tick();
        video_on = 1'b1;
        x        = 10'd639;
        y        = 10'd0;
        tick();
        chk("wrap_rd_addr", 32'(bg_ram_rd_addr), 32'd0);
        tick();
        chk("wrap_rom_addr", 32'(tile_rom_addr), 32'h310E);
        y = 10'd479;
        tick();
        chk("lastrow_rd_addr", 32'(bg_ram_rd_addr), 32'd1160);
        tick();
        chk("lastrow_rom_addr", 32'(tile_rom_addr), 32'h00FE);
        repeat (2) tick();
        chk("disabled_rgb", 32'(bg_rgb), 32'd0);
        chk("disabled_on", 32'(bg_pixel_on), 32'd0);
        chk("disabled_vid", 32'(bg_video_on), 32'd1);

        // Offset latched during blanking, ignored while active.
        video_on    = 1'b0;
        bg_x_offset = 4'd3;
        tick();
        video_on    = 1'b1;
        x           = 10'd100;
        y           = 10'd0;
        bg_x_offset = 4'd7;
        tick();
        chk("latch_hold_rd_addr", 32'(bg_ram_rd_addr), 32'd6);
        tick();
        chk("latch_hold_rom_addr", 32'(tile_rom_addr), 32'h0007);
        video_on = 1'b0;
        tick();
        video_on = 1'b1;
        y        = 10'd16;
        tick();
        chk("latch_new_rd_addr", 32'(bg_ram_rd_addr), 32'd46);
        tick();
        chk("latch_new_rom_addr", 32'(tile_rom_addr), 32'h000B);

        // Transparent key, opaque control, then y beyond the active area.
        x         = 10'd0;
        y         = 10'd0;
        rom_match = 14'h3107;
        rom_word  = 12'hF0F;
        repeat (2) tick();
        chk("key_rom_addr", 32'(tile_rom_addr), 32'h3107);
        repeat (2) tick();
        chk("key_rgb", 32'(bg_rgb), 32'd0);
        chk("key_on", 32'(bg_pixel_on), 32'd0);
        chk("key_vid", 32'(bg_video_on), 32'd1);
        rom_word = 12'h777;
        repeat (2) tick();
        chk("opaque_rgb", 32'(bg_rgb), 32'h777);
        chk("opaque_on", 32'(bg_pixel_on), 32'd1);
        y = 10'd480;
        repeat (2) tick();
        chk("vblank_rom_addr", 32'(tile_rom_addr), 32'h3107);
        repeat (2) tick();
        chk("vblank_rgb", 32'(bg_rgb), 32'd0);
        chk("vblank_on", 32'(bg_pixel_on), 32'd0);
        chk("vblank_vid", 32'(bg_video_on), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
